// File: rtl/life_engine.sv
// 8x8 Game of Life engine. A frame is loaded from a byte-wide memory, then each
// step evaluates one cell per cycle into a shadow grid and swaps it in at the end.
module life_engine #(
  parameter logic [7:0]  ALIVE_VALUE = 8'hFF,
  parameter int unsigned WRAP        = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  output logic [10:0] mem_addr,
  input  logic [7:0]  mem_data,
  input  logic [5:0]  pix_addr,
  output logic [7:0]  pixel_value,
  output logic        busy,
  output logic        done,
  output logic [15:0] generation
);

  localparam int unsigned CELLS  = 64;
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned GEN_W  = 16;
  localparam bit          WRAP_EN = (WRAP != 0);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE} state_t;

  state_t              r_state;
  logic [CELLS-1:0]    r_cur;
  logic [CELLS-1:0]    r_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [7:0]          r_pixel;
  logic                r_busy;
  logic                r_done;
  logic [GEN_W-1:0]    r_gen;

  logic [5:0] w_idx;
  logic [2:0] w_row, w_col, w_rm, w_rp, w_cm, w_cp;
  logic       w_vrm, w_vrp, w_vcm, w_vcp;
  logic [7:0] w_nb;
  logic [3:0] w_count;
  logic       w_alive;

  // Neighbour coordinates wrap in 3 bits; the valid flags mask them off at the edges when not toroidal.
  assign w_idx = r_cnt[5:0];
  assign w_row = w_idx[5:3];
  assign w_col = w_idx[2:0];
  assign w_rm  = w_row - 3'd1;
  assign w_rp  = w_row + 3'd1;
  assign w_cm  = w_col - 3'd1;
  assign w_cp  = w_col + 3'd1;
  assign w_vrm = WRAP_EN || (w_row != 3'd0);
  assign w_vrp = WRAP_EN || (w_row != 3'd7);
  assign w_vcm = WRAP_EN || (w_col != 3'd0);
  assign w_vcp = WRAP_EN || (w_col != 3'd7);

  assign w_nb = {
    r_cur[{w_rm,  w_cm}]  & w_vrm & w_vcm,
    r_cur[{w_rm,  w_col}] & w_vrm,
    r_cur[{w_rm,  w_cp}]  & w_vrm & w_vcp,
    r_cur[{w_row, w_cm}]  & w_vcm,
    r_cur[{w_row, w_cp}]  & w_vcp,
    r_cur[{w_rp,  w_cm}]  & w_vrp & w_vcm,
    r_cur[{w_rp,  w_col}] & w_vrp,
    r_cur[{w_rp,  w_cp}]  & w_vrp & w_vcp
  };

  always_comb begin
    w_count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_count = w_count + 4'(w_nb[i]);
    end
  end

  assign w_alive = (w_count == 4'd3) || (r_cur[w_idx] && (w_count == 4'd2));

  // Control FSM plus grid/counter state; start wins over step when both arrive in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cur      <= '0;
      r_nxt      <= '0;
      r_cnt      <= '0;
      r_mem_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_gen      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_LOAD;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_mem_addr <= '0;
          end else if (step) begin
            r_state <= S_COMPUTE;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_LOAD: begin
          // Read data trails the address by one cycle, so cell k lands when the counter is k+1.
          if (r_cnt != 7'd0) begin
            r_cur[6'(r_cnt - 7'd1)] <= (mem_data != 8'h00);
          end
          if (r_cnt == 7'd64) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_gen      <= '0;
            r_mem_addr <= '0;
          end else begin
            r_cnt      <= r_cnt + 7'd1;
            r_mem_addr <= (r_cnt < 7'd63) ? ADDR_W'(r_cnt + 7'd1) : '0;
          end
        end
        S_COMPUTE: begin
          r_nxt[w_idx] <= w_alive;
          if (r_cnt == 7'd63) begin
            r_cur   <= {w_alive, r_nxt[62:0]};
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_gen   <= r_gen + 16'd1;
          end else begin
            r_cnt <= r_cnt + 7'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Display read port: one cycle of latency from pix_addr.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pixel <= 8'h00;
    end else begin
      r_pixel <= r_cur[pix_addr] ? ALIVE_VALUE : 8'h00;
    end
  end

  assign mem_addr    = r_mem_addr;
  assign pixel_value = r_pixel;
  assign busy        = r_busy;
  assign done        = r_done;
  assign generation  = r_gen;

endmodule

// File: doc/life_engine.md
LIFE_ENGINE -- requirements
Module: life_engine

Interface
REQ-001 Parameter ALIVE_VALUE, default 8'hFF, is the pixel_value byte driven for a live cell.
REQ-002 Parameter WRAP, default 1: 1 makes the grid edges toroidal; 0 treats out-of-grid neighbours as dead.
REQ-003 clk  input  1  is the single clock; all logic is rising-edge.
REQ-004 rst  input  1  is the reset: synchronous, active-high.
REQ-005 start  input  1  is a single-cycle pulse that loads the initial frame from the cell memory.
REQ-006 step  input  1  is a single-cycle pulse that advances the grid one generation.
REQ-007 mem_addr  output  11  is the read address to the cell memory, which returns data with 1-cycle latency.
REQ-008 mem_data  input  8  is the memory read data; nonzero means alive.
REQ-009 pix_addr  input  6  is the display-side cell index, row*8+col.
REQ-010 pixel_value  output  8  is the state of cell pix_addr: ALIVE_VALUE if alive, 8'h00 if dead.
REQ-011 busy  output  1  is high while in LOAD or COMPUTE.
REQ-012 done  output  1  is a one-cycle pulse at the end of a LOAD or COMPUTE pass.
REQ-013 generation  output  16  is the count of generations computed since the last load.

Function
REQ-014 The grid SHALL be a 64-bit current-state register cur plus a 64-bit next-state register nxt; cell idx uses row=idx[5:3], col=idx[2:0].
REQ-015 The FSM SHALL have states IDLE, LOAD and COMPUTE; start and step are honoured only in IDLE and are ignored while busy.
REQ-016 If start and step are both high in the same IDLE cycle, start SHALL win and step SHALL be dropped.
REQ-017 LOAD: when start is sampled at cycle T, mem_addr SHALL equal k at cycle T+1+k for k=0..63; cur[k] SHALL take (mem_data!=0) at T+2+k.
REQ-018 LOAD completion: done SHALL pulse at T+66, the FSM SHALL return to IDLE, and generation SHALL clear to 0 in that same cycle.
REQ-019 mem_addr SHALL be 0 outside LOAD; bits [10:6] SHALL always be 0.
REQ-020 COMPUTE: when step is sampled at cycle T, cell k SHALL be evaluated at cycle T+1+k from cur only, and the result written to nxt[k].
REQ-021 The neighbour count SHALL be the sum of the 8 adjacent cells, a 4-bit value 0..8.
REQ-022 The next-state rule: an alive cell with count 2 or 3 SHALL stay alive; a dead cell with count exactly 3 SHALL become alive; every other cell SHALL become dead.
REQ-023 With WRAP=1, neighbour row and column SHALL be computed modulo 8 (3-bit wrap); with WRAP=0, neighbours outside 0..7 SHALL count as dead.
REQ-024 COMPUTE completion: at T+65, cur SHALL take nxt (including the cell-63 result), done SHALL pulse, generation SHALL increment by 1, and the FSM SHALL return to IDLE.
REQ-025 cur SHALL not change at any time during COMPUTE, so pixel_value shows the old frame until the swap.
REQ-026 generation SHALL wrap from 16'hFFFF to 16'h0000.
REQ-027 pixel_value SHALL be registered, reflecting cur[pix_addr] of the previous cycle (1-cycle latency).
REQ-028 A new start or step SHALL be accepted in the cycle immediately after done.

Reset
REQ-029 When rst is high at a clock edge: cur=0, nxt=0, state=IDLE, mem_addr=0, busy=0, done=0, generation=0, pixel_value=8'h00.
REQ-030 rst asserted mid-LOAD or mid-COMPUTE SHALL abort the operation with no done pulse and leave the grid cleared.
REQ-031 rst SHALL take priority over start and step in the same cycle.

Verification
REQ-032 Load memory with a horizontal blinker at cells 27,28,29, then start -> done at T+66 with generation=0; step -> done 65 cycles later, vertical blinker at cells 20,28,36, generation=1.
REQ-033 Load a block still life at cells 0,1,8,9 with WRAP=1; step three times -> grid unchanged, generation=3.
REQ-034 Load a glider touching column 7 with WRAP=1; step 4 times -> glider shifted one cell diagonally and wrapped into column 0; with WRAP=0 the pattern loses cells at the edge.
REQ-035 Assert step at the cycle after start, and later step during COMPUTE -> both ignored; start and step in the same IDLE cycle -> only LOAD runs, with mem_addr sweeping 0..63.
REQ-036 Assert rst at cycle 30 of COMPUTE -> next cycle busy=0, done never pulses, pixel_value=8'h00 for every pix_addr, generation=0.
REQ-037 Sweep pix_addr 0..63 after load with ALIVE_VALUE=8'hA5 -> pixel_value returns 8'hA5 or 8'h00 per cell, one cycle after each address.
